// File: rtl/topo_stream_gen.sv
// topo_stream_gen: post-order (topological) record stream generator.
// Walks a CSR graph (node table + edge list) from a root with an explicit
// DFS stack and emits one record per reachable node, children first.
// Record: {node_id, degree} header, then `degree` words {16'h0, child_id}.
// Optional feature macro: TOPO_CYCLE_CHECK_EN (back-edge detection; a back
// edge aborts the walk with error).
module topo_stream_gen #(
  parameter int NUM_NODES   = 1024,
  parameter int NUM_EDGES   = 4096,
  parameter int STACK_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] root_id,
  output logic [15:0] node_addr,
  input  logic [31:0] node_data,
  output logic [15:0] edge_addr,
  input  logic [15:0] edge_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH - 1) : 1;
  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, ROOT, PUSH, SCAN, CHECK, EMIT_HDR, EMIT_CHILD, POP, DONE
  } state_t;

  typedef struct packed {
    logic [15:0] node;
    logic [15:0] base;
    logic [15:0] deg;
    logic [15:0] idx;
  } frame_t;

  state_t        state;
  frame_t        top;                          // top-of-stack frame lives in flops
  frame_t        stack_mem [STACK_DEPTH-1];    // frames below the top
  logic [NUM_NODES-1:0] visited;
  logic [DW-1:0] depth;                        // frames held, including top
  logic [NW-1:0] clr_cnt;
  logic [15:0]   root_q;
  logic [15:0]   pend_node;                    // node whose entry is being fetched for PUSH
  logic [15:0]   cnt;                          // child word index while emitting

  logic [16:0]   scan_addr;
  logic          root_ok, child_ok, child_last, last_frame;
  logic [NW-1:0] child_idx;
  logic [SW-1:0] wr_ptr, rd_ptr;

  assign scan_addr  = {1'b0, top.base} + {1'b0, top.idx};
  assign root_ok    = {16'h0, root_q} < 32'(NUM_NODES);
  assign child_ok   = {16'h0, edge_data} < 32'(NUM_NODES);
  assign child_idx  = edge_data[NW-1:0];
  assign child_last = (cnt == top.deg - 16'd1);
  assign last_frame = (depth == DW'(1));
  assign wr_ptr     = SW'(depth - DW'(1));
  assign rd_ptr     = SW'(depth - DW'(2));

`ifdef TOPO_CYCLE_CHECK_EN
  logic [NUM_NODES-1:0] on_stack;
  logic                 os_we, os_val;
  logic [NW-1:0]        os_idx;
`endif

  // Stream outputs and memory addresses decode from the registered state.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    out_valid = (state == EMIT_HDR) || (state == EMIT_CHILD);
    out_data  = '0;
    out_last  = 1'b0;
    node_addr = '0;
    edge_addr = '0;
    case (state)
      ROOT:     node_addr = root_q;
      CHECK:    node_addr = edge_data;
      SCAN:     edge_addr = scan_addr[15:0];
      EMIT_HDR: begin
        out_data  = {top.node, top.deg};
        out_last  = last_frame && (top.deg == 16'd0);
        edge_addr = top.base;   // prefetch child 0 while the header is presented
      end
      EMIT_CHILD: begin
        out_data  = {16'h0, edge_data};
        out_last  = last_frame && child_last;
        // Advance the address only in a transfer cycle so a stall holds edge_data.
        edge_addr = top.base + cnt + {15'h0, (out_ready && !child_last)};
      end
      default: ;
    endcase
  end

  // Write enables for the visited vector, the frame store and the on-stack vector.
  logic          vis_we, vis_val, stk_we;
  logic [NW-1:0] vis_idx;
  always_comb begin
    vis_we  = 1'b0;
    vis_val = 1'b0;
    vis_idx = clr_cnt;
    stk_we  = 1'b0;
`ifdef TOPO_CYCLE_CHECK_EN
    os_we   = 1'b0;
    os_val  = 1'b0;
    os_idx  = clr_cnt;
`endif
    case (state)
      CLEAR: begin
        vis_we = 1'b1;
`ifdef TOPO_CYCLE_CHECK_EN
        os_we  = 1'b1;
`endif
      end
      ROOT: begin
        vis_we  = root_ok;
        vis_val = 1'b1;
        vis_idx = root_q[NW-1:0];
      end
      CHECK: begin
        vis_we  = child_ok && !visited[child_idx];
        vis_val = 1'b1;
        vis_idx = child_idx;
      end
      PUSH: begin
        stk_we = (depth != '0) && (depth != DW'(STACK_DEPTH));
`ifdef TOPO_CYCLE_CHECK_EN
        os_we  = (depth != DW'(STACK_DEPTH));
        os_val = 1'b1;
        os_idx = pend_node[NW-1:0];
`endif
      end
`ifdef TOPO_CYCLE_CHECK_EN
      POP: begin
        os_we  = 1'b1;
        os_idx = top.node[NW-1:0];
      end
`endif
      default: ;
    endcase
  end

  // Storage arrays: initialised by the CLEAR sweep, not by reset.
  // NOTE: memories carry no reset; the CLEAR state sweeps the bit-vectors
  // and stack entries are always written before they are read.
  always_ff @(posedge clk) begin
    if (vis_we) visited[vis_idx] <= vis_val;
    if (stk_we) stack_mem[wr_ptr] <= top;
`ifdef TOPO_CYCLE_CHECK_EN
    if (os_we) on_stack[os_idx] <= os_val;
`endif
  end

  // Traversal FSM: clear, root fetch, DFS scan/push, record emission, pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      top       <= '0;
      depth     <= '0;
      clr_cnt   <= '0;
      root_q    <= '0;
      pend_node <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          root_q  <= root_id;
          clr_cnt <= '0;
          depth   <= '0;
          busy    <= 1'b1;
          done    <= 1'b0;
          error   <= 1'b0;
          state   <= CLEAR;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == NW'(NUM_NODES - 1)) state <= ROOT;
        end
        ROOT: begin
          if (!root_ok) begin
            error <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            pend_node <= root_q;
            state     <= PUSH;
          end
        end
        PUSH: begin
          if (depth == DW'(STACK_DEPTH)) begin
            error <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            top   <= '{node: pend_node, base: node_data[31:16],
                       deg: node_data[15:0], idx: 16'd0};
            depth <= depth + DW'(1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (top.idx < top.deg) begin
            if (scan_addr >= 17'(NUM_EDGES)) begin
              error <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= DONE;
            end else begin
              state <= CHECK;
            end
          end else begin
            state <= EMIT_HDR;
          end
        end
        CHECK: begin
          top.idx <= top.idx + 16'd1;
          if (!child_ok) begin
            error <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else if (!visited[child_idx]) begin
            pend_node <= edge_data;
            state     <= PUSH;
          end
`ifdef TOPO_CYCLE_CHECK_EN
          else if (on_stack[child_idx]) begin
            error <= 1'b1; done <= 1'b1; busy <= 1'b0; state <= DONE;
          end
`endif
          else begin
            state <= SCAN;
          end
        end
        EMIT_HDR: if (out_ready) begin
          cnt   <= '0;
          state <= (top.deg == 16'd0) ? POP : EMIT_CHILD;
        end
        EMIT_CHILD: if (out_ready) begin
          if (child_last) state <= POP;
          else            cnt   <= cnt + 16'd1;
        end
        POP: begin
          if (last_frame) begin
            depth <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            depth <= depth - DW'(1);
            top   <= stack_mem[rd_ptr];
            state <= SCAN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_topo_stream_gen.sv
// Self-checking bench for topo_stream_gen: directed graphs from the test plan
// plus randomized graphs, checked against a queue-based DFS reference model.
`timescale 1ns/1ps
module tb_topo_stream_gen;

  localparam int NN = 16;
  localparam int NE = 64;
  localparam int SD = 4;
`ifdef TOPO_CYCLE_CHECK_EN
  localparam bit CYC = 1'b1;
`else
  localparam bit CYC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] root_id;
  logic [15:0] node_addr;
  logic [31:0] node_data;
  logic [15:0] edge_addr;
  logic [15:0] edge_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy, done, error;

  always #5 clk = ~clk;

  topo_stream_gen #(.NUM_NODES(NN), .NUM_EDGES(NE), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .root_id(root_id),
    .node_addr(node_addr), .node_data(node_data),
    .edge_addr(edge_addr), .edge_data(edge_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  // Graph memories with one-cycle synchronous read.
  logic [31:0] node_mem [NN];
  logic [15:0] edge_mem [NE];
  always @(posedge clk) begin
    node_data <= (int'(node_addr) < NN) ? node_mem[int'(node_addr)] : 32'hDEAD_BEEF;
    edge_data <= (int'(edge_addr) < NE) ? edge_mem[int'(edge_addr)] : 16'hFFFF;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q [$];
  logic [31:0] lit_q [$];
  bit          exp_err;

  // Recursive-DFS semantics unrolled with a node stack and a per-node
  // "next child" index; records are appended when a node has no children left.
  task automatic build_model(input int root);
    int stk [$];
    int nidx [NN];
    bit vis  [NN];
    bit onst [NN];
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < NN; i++) begin nidx[i] = 0; vis[i] = 0; onst[i] = 0; end
    if (root >= NN) begin exp_err = 1'b1; return; end
    vis[root] = 1'b1;
    stk.push_back(root);
    onst[root] = 1'b1;
    while (stk.size() != 0) begin
      int n, deg, base;
      n    = stk[stk.size()-1];
      deg  = int'(node_mem[n][15:0]);
      base = int'(node_mem[n][31:16]);
      if (nidx[n] < deg) begin
        int e, c;
        e = base + nidx[n];
        nidx[n]++;
        if (e >= NE) begin exp_err = 1'b1; return; end
        c = int'(edge_mem[e]);
        if (c >= NN) begin exp_err = 1'b1; return; end
        if (!vis[c]) begin
          vis[c] = 1'b1;
          if (stk.size() == SD) begin exp_err = 1'b1; return; end
          stk.push_back(c);
          onst[c] = 1'b1;
        end else if (CYC && onst[c]) begin
          exp_err = 1'b1; return;
        end
      end else begin
        exp_q.push_back({16'(n), 16'(deg)});
        for (int k = 0; k < deg; k++) exp_q.push_back({16'h0, edge_mem[base+k]});
        void'(stk.pop_back());
        onst[n] = 1'b0;
      end
    end
  endtask

  task automatic pin_model(input string name);
    check({name, "_len"}, exp_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), exp_q[i], lit_q[i]);
  endtask

  // ---------------- graph builders ----------------
  task automatic clear_graph();
    for (int i = 0; i < NN; i++) node_mem[i] = 32'h0;
    for (int i = 0; i < NE; i++) edge_mem[i] = 16'h0;
  endtask

  task automatic set_node(input int n, input int base, input int deg);
    node_mem[n] = {16'(base), 16'(deg)};
  endtask

  task automatic random_graph(input bit dag);
    int base = 0;
    clear_graph();
    for (int n = 0; n < NN; n++) begin
      int deg;
      deg = (dag && n == NN-1) ? 0 : int'($urandom_range(0, 3));
      set_node(n, base, deg);
      for (int k = 0; k < deg; k++)
        edge_mem[base+k] = dag ? 16'($urandom_range(n+1, NN-1)) : 16'($urandom_range(0, NN-1));
      base += deg;
    end
    if ($urandom_range(0, 7) == 0) edge_mem[$urandom_range(0, base > 0 ? base-1 : 0)] = 16'(NN + 3);
    if ($urandom_range(0, 7) == 0) begin
      int n = $urandom_range(0, NN-1);
      set_node(n, NE-2, 3);
      edge_mem[NE-2] = 16'($urandom_range(0, NN-1));
      edge_mem[NE-1] = 16'($urandom_range(0, NN-1));
    end
  endtask

  // ---------------- consumer ready driver ----------------
  int rmode = 0;
  int rctr  = 0;
  int stall_at = 0;
  always @(posedge clk) begin
    #1;
    rctr++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = rctr[0];
      2:       out_ready = 1'($urandom_range(0, 1));
      3:       out_ready = (rctr >= stall_at && rctr < stall_at + 5) ? 1'b0 : rctr[0];
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- compare process ----------------
  bit mon_en = 1'b0;
  int widx, first_edge, last_edge, start_edge;
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid) begin
      if (widx < exp_q.size()) begin
        check("word", out_data, exp_q[widx]);
        check("last", out_last, (!exp_err && widx == exp_q.size()-1));
      end else begin
        check("extra_word_valid", out_valid, 1'b0);
      end
      if (first_edge < 0) first_edge = cyc;
      if (out_ready) begin
        if (out_last) last_edge = cyc + 1;
        widx++;
      end
    end
  end

  task automatic start_run(input int root, input int mode);
    build_model(root);
    widx = 0; first_edge = -1; last_edge = -1;
    rmode = mode;
    stall_at = rctr + 30;
    @(posedge clk); #2;
    start = 1'b1; root_id = 16'(root); start_edge = cyc + 1; mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int t = 0;
    int done_cyc;
    do begin @(negedge clk); t++; end while (!done && t < 4000);
    done_cyc = cyc;
    check({name, "_done"}, done, 1'b1);
    check({name, "_words"}, widx, exp_q.size());
    check({name, "_error"}, error, exp_err);
    check({name, "_busy"}, busy, 1'b0);
    if (!exp_err) begin
      check({name, "_last_seen"}, (last_edge >= 0), 1'b1);
      check({name, "_done_lat"}, done_cyc - last_edge, 1);
    end
    if (first_edge >= 0) check({name, "_first_lat"}, ((first_edge - start_edge) >= NN + 3), 1'b1);
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic load_chain();
    clear_graph();
    set_node(0, 0, 1); edge_mem[0] = 16'd1;
    set_node(1, 1, 1); edge_mem[1] = 16'd2;
    set_node(2, 2, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; root_id = '0; out_ready = 1'b1;
    clear_graph();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_out_data",  out_data,  32'h0);
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_error",     error,     1'b0);
    check("rst_node_addr", node_addr, 16'h0);
    check("rst_edge_addr", edge_addr, 16'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Chain 0->1->2, ready tied high.
    load_chain();
    start_run(0, 0);
    lit_q = '{32'h00020000, 32'h00010001, 32'h00000002, 32'h00000001, 32'h00000001};
    pin_model("chain_model");
    finish_run("chain");

    // Same chain with toggling ready and a 5-cycle stall.
    start_run(0, 3);
    finish_run("chain_stall");

    // Diamond 0->{1,2}, 1->3, 2->3.
    clear_graph();
    set_node(0, 0, 2); edge_mem[0] = 16'd1; edge_mem[1] = 16'd2;
    set_node(1, 2, 1); edge_mem[2] = 16'd3;
    set_node(2, 3, 1); edge_mem[3] = 16'd3;
    set_node(3, 4, 0);
    start_run(0, 1);
    lit_q = '{32'h00030000, 32'h00010001, 32'h00000003, 32'h00020001, 32'h00000003,
              32'h00000002, 32'h00000001, 32'h00000002};
    pin_model("diamond_model");
    finish_run("diamond");

    // Cycle 0->1->0.
    clear_graph();
    set_node(0, 0, 1); edge_mem[0] = 16'd1;
    set_node(1, 1, 1); edge_mem[1] = 16'd0;
    start_run(0, 0);
`ifdef TOPO_CYCLE_CHECK_EN
    check("cycle_model_err", exp_err, 1'b1);
    check("cycle_model_len", exp_q.size(), 0);
`else
    check("cycle_model_err", exp_err, 1'b0);
    lit_q = '{32'h00010001, 32'h00000000, 32'h00000001, 32'h00000001};
    pin_model("cycle_model");
`endif
    finish_run("cycle");

    // Chain of 5 nodes overflows a 4-frame stack.
    clear_graph();
    for (int i = 0; i < 4; i++) begin set_node(i, i, 1); edge_mem[i] = 16'(i + 1); end
    set_node(4, 4, 0);
    start_run(0, 0);
    check("deep_model_err", exp_err, 1'b1);
    check("deep_model_len", exp_q.size(), 0);
    finish_run("deep");

    // Root id out of range.
    start_run(NN + 4, 0);
    check("badroot_model_err", exp_err, 1'b1);
    finish_run("badroot");

    // Reset in the middle of a stalled stream, then restart at root 2.
    load_chain();
    start_run(0, 4);
    begin
      int t = 0;
      while (!out_valid && t < 300) begin @(negedge clk); t++; end
    end
    check("rstmid_valid_before", out_valid, 1'b1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_out_last",  out_last,  1'b0);
    check("rstmid_out_data",  out_data,  32'h0);
    check("rstmid_busy",      busy,      1'b0);
    @(posedge clk); #2 rst = 1'b0;
    start_run(2, 0);
    lit_q = '{32'h00020000};
    pin_model("restart_model");
    finish_run("restart");

    // Randomized graphs, roots and consumer behaviour.
    for (int it = 0; it < 30; it++) begin
      random_graph(it % 3 != 0);
      start_run($urandom_range(0, NN-1), $urandom_range(0, 3));
      finish_run($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
